// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - frame request and serial status signals of the UART frame transmitter
interface uart_frame_tx_if #(
  parameter int BYTE_NUM = 17
);
  logic                      tx_start;
  logic [8*BYTE_NUM-1:0]     tx_frame;
  logic                      uart_txd;
  logic                      tx_busy;
  logic                      tx_byte_done;
  logic                      tx_done;

  modport master (
    output tx_start, tx_frame,
    input  uart_txd, tx_busy, tx_byte_done, tx_done
  );

  modport slave (
    input  tx_start, tx_frame,
    output uart_txd, tx_busy, tx_byte_done, tx_done
  );
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - 8N1 UART transmitter for a fixed-length multi-byte frame
module uart_frame_tx #(
  parameter int CLK_FREQ = 27000000,
  parameter int UART_BPS = 9600,
  parameter int BYTE_NUM = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_frame_tx_if.slave   bus
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_W = ($clog2(BAUD_CNT_MAX) > 16) ? $clog2(BAUD_CNT_MAX) : 16;
  localparam int BYTE_W = ($clog2(BYTE_NUM) > 5) ? $clog2(BYTE_NUM) : 5;
  localparam int FRAME_W = 8 * BYTE_NUM;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 byte_done_q, byte_done_d;
  logic                 done_q, done_d;

  logic                 baud_last;
  logic [7:0]           cur_byte;

  // The shadow shifts left by a byte after each stop bit, so the byte in flight is always on top.
  assign cur_byte  = shadow_q[FRAME_W-1 -: 8];
  assign baud_last = (baud_cnt_q == BAUD_W'(BAUD_CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shadow_q    <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shadow_d    = shadow_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    byte_done_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start && !busy_q) begin
          shadow_d   = bus.tx_frame;
          byte_cnt_d = '0;
          baud_cnt_d = '0;
          state_d    = START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
          txd_d      = cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = cur_byte[bit_cnt_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_d  = '0;
          byte_done_d = 1'b1;
          // Next start bit follows the stop bit directly; no idle gap between bytes.
          if (byte_cnt_q < BYTE_W'(BYTE_NUM - 1)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            shadow_d   = shadow_q << 8;
            state_d    = START;
            txd_d      = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.uart_txd     = txd_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_byte_done = byte_done_q;
  assign bus.tx_done      = done_q;
endmodule
